// File: rtl/tnn_pkg.sv
// tnn_pkg: shared constants and types for the ternary-neuron sequencer.
//   FEAT_W   operand width, fixed by the 6-operand comparator
//   slot_e   operand slot a..f, also the entry offset within a neuron's table row
//   state_e  sequencer states
//   zero_idx index value that selects the constant-zero operand (== N_FEAT)
package tnn_pkg;
    localparam int FEAT_W = 3;
    typedef enum logic [2:0] {SLOT_A, SLOT_B, SLOT_C, SLOT_D, SLOT_E, SLOT_F} slot_e;
    localparam int N_SLOT = 6;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    function automatic int zero_idx(input int n_feat);
        return n_feat;
    endfunction
endpackage

// File: rtl/tnn_operand_mux.sv
// tnn_operand_mux: picks one FEAT_W-bit feature from a packed sample by index.
//   sample_i  packed features, feature k at [k*FEAT_W +: FEAT_W]
//   idx_i     feature index; any value >= N_FEAT selects zero
//   op_o      selected operand
module tnn_operand_mux
    import tnn_pkg::*;
#(
    parameter int N_FEAT = 11,
    parameter int IDX_W  = $clog2(N_FEAT + 1)
) (
    input  logic [N_FEAT*FEAT_W-1:0] sample_i,
    input  logic [IDX_W-1:0]         idx_i,
    output logic [FEAT_W-1:0]        op_o
);
    logic [FEAT_W-1:0] feat [N_FEAT];
    for (genvar k = 0; k < N_FEAT; k++) begin : g_feat
        assign feat[k] = sample_i[k*FEAT_W +: FEAT_W];
    end
    assign op_o = (idx_i < IDX_W'(N_FEAT)) ? feat[idx_i] : '0;
endmodule

// File: rtl/tnn_neuron_sequencer.sv
// tnn_neuron_sequencer: time-multiplexes one feature sample across N_NEUR ternary neurons.
//   clk, rst              clock, synchronous active-high reset
//   in_valid_i/in_ready_o sample handshake, in_feat_i packed features
//   cfg_we_i/addr/data    feature-index table write (addr = neuron*6 + slot)
//   cfg_err_o             one-cycle pulse after a dropped table write
//   op_a_o..op_f_o        comparator operands, cmp_i comparator fire bit
//   hid_valid_o/ready_i   hidden-vector handshake, hid_o bit n = neuron n fired
// Build option TNN_SEQ_OPREG_EN: registers the operand buses, adding one cycle of latency.
module tnn_neuron_sequencer
    import tnn_pkg::*;
#(
    parameter int N_FEAT = 11,
    parameter int N_NEUR = 8,
    parameter int IDX_W  = $clog2(N_FEAT + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [N_FEAT*FEAT_W-1:0]        in_feat_i,
    input  logic                            cfg_we_i,
    input  logic [$clog2(N_NEUR*N_SLOT)-1:0] cfg_addr_i,
    input  logic [IDX_W-1:0]                cfg_data_i,
    output logic                            cfg_err_o,
    output logic [FEAT_W-1:0]               op_a_o,
    output logic [FEAT_W-1:0]               op_b_o,
    output logic [FEAT_W-1:0]               op_c_o,
    output logic [FEAT_W-1:0]               op_d_o,
    output logic [FEAT_W-1:0]               op_e_o,
    output logic [FEAT_W-1:0]               op_f_o,
    input  logic                            cmp_i,
    output logic                            hid_valid_o,
    input  logic                            hid_ready_i,
    output logic [N_NEUR-1:0]               hid_o
);
    localparam int AW = $clog2(N_NEUR * N_SLOT);
    localparam int NB = $clog2(N_NEUR);
    localparam int CW = $clog2(N_NEUR + 1);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;
    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(zero_idx(N_FEAT));
`ifdef TNN_SEQ_OPREG_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif
    localparam logic [CW-1:0] LAST = CW'(N_NEUR - 1 + LAG);

    logic [1:0]                state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [N_FEAT*FEAT_W-1:0]  sample_q, sample_d;
    logic [N_NEUR-1:0]         hid_q, hid_d;
    logic                      err_q;
    logic [IDX_W-1:0]          tbl_q [N_NEUR*N_SLOT];
    logic                      drive, cfg_ok, cap_en;
    logic [NB-1:0]             cap_n;
    logic [AW-1:0]             base;
    logic [IDX_W-1:0]          sel_idx [N_SLOT];
    logic [N_SLOT-1:0][FEAT_W-1:0] mux_op, ops;

    // cnt_q runs LAG cycles ahead of the neuron being captured
    assign drive  = (state_q == S_RUN) && (cnt_q < CW'(N_NEUR));
    assign base   = AW'(cnt_q[NB-1:0]) * AW'(N_SLOT);
    assign cap_en = (LAG == 0) || (cnt_q != '0);
    assign cap_n  = NB'(cnt_q - CW'(LAG));
    assign cfg_ok = cfg_we_i && (state_q == S_IDLE) && (cfg_addr_i < AW'(N_NEUR * N_SLOT));

    for (genvar s = 0; s < N_SLOT; s++) begin : g_slot
        assign sel_idx[s] = drive ? tbl_q[base + AW'(s)] : ZERO_IDX;
        tnn_operand_mux #(.N_FEAT(N_FEAT), .IDX_W(IDX_W)) u_mux (
            .sample_i (sample_q),
            .idx_i    (sel_idx[s]),
            .op_o     (mux_op[s])
        );
    end

`ifdef TNN_SEQ_OPREG_EN
    logic [N_SLOT-1:0][FEAT_W-1:0] op_q;
    always_ff @(posedge clk) op_q <= rst ? '0 : mux_op;
    assign ops = op_q;
`else
    assign ops = mux_op;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        hid_d    = hid_q;
        case (state_q)
            S_IDLE: if (in_valid_i) begin
                sample_d = in_feat_i;
                cnt_d    = '0;
                hid_d    = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cap_en) hid_d[cap_n] = cmp_i;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: if (hid_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
            hid_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < N_NEUR*N_SLOT; i++) tbl_q[i] <= ZERO_IDX;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            hid_q    <= hid_d;
            err_q    <= cfg_we_i && !cfg_ok;
            if (cfg_ok) tbl_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign hid_valid_o = (state_q == S_DONE);
    assign hid_o       = hid_q;
    assign cfg_err_o   = err_q;
    assign op_a_o      = ops[SLOT_A];
    assign op_b_o      = ops[SLOT_B];
    assign op_c_o      = ops[SLOT_C];
    assign op_d_o      = ops[SLOT_D];
    assign op_e_o      = ops[SLOT_E];
    assign op_f_o      = ops[SLOT_F];
endmodule

// File: tb/tb_tnn_neuron_sequencer.sv
// tb_tnn_neuron_sequencer: directed bench for tnn_neuron_sequencer with an ideal comparator stub.
module tb_tnn_neuron_sequencer;
    localparam int N_FEAT = 11;
    localparam int N_NEUR = 8;
    localparam int IDX_W  = 4;
    localparam int AW     = 6;
`ifdef TNN_SEQ_OPREG_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif
    localparam int LAT = N_NEUR + LAG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [N_FEAT*3-1:0] in_feat = '0;
    logic cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [IDX_W-1:0] cfg_data = '0;
    logic cfg_err;
    logic [2:0] op_a, op_b, op_c, op_d, op_e, op_f;
    logic cmp;
    logic hid_valid;
    logic hid_ready = 1'b1;
    logic [N_NEUR-1:0] hid;
    logic [5:0] pos_sum, neg_sum;
    logic [17:0] op_log [0:31];
    int lat;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    // ideal comparator: fire when positive slots outweigh negative slots
    assign pos_sum = 6'(op_a) + 6'(op_b);
    assign neg_sum = 6'(op_c) + 6'(op_d) + 6'(op_e) + 6'(op_f);
    assign cmp = pos_sum > neg_sum;

    tnn_neuron_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_feat_i(in_feat),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_err_o(cfg_err),
        .op_a_o(op_a), .op_b_o(op_b), .op_c_o(op_c), .op_d_o(op_d), .op_e_o(op_e), .op_f_o(op_f),
        .cmp_i(cmp), .hid_valid_o(hid_valid), .hid_ready_i(hid_ready), .hid_o(hid)
    );

    function automatic logic [N_FEAT*3-1:0] mk(input logic [2:0] f0, input logic [2:0] f1);
        mk = '0;
        mk[2:0] = f0;
        mk[5:3] = f1;
    endfunction

    task automatic cfg_write(input logic [AW-1:0] a, input logic [IDX_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic run_sample(input logic [N_FEAT*3-1:0] f, input logic do_cfg,
                              input logic [AW-1:0] a, input logic [IDX_W-1:0] d);
        in_feat = f; in_valid = 1'b1; cfg_we = do_cfg; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        lat = 99;
        for (int k = 0; k < 24; k++) begin
            if (hid_valid) begin
                lat = k;
                break;
            end
            op_log[k] = {op_a, op_b, op_c, op_d, op_e, op_f};
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_run;
        @(posedge clk); #1;
    endtask

    task automatic wait_valid;
        for (int k = 0; k < 24 && !hid_valid; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        total++; if (hid_valid !== 1'b0) $display("FAIL reset_hid_valid: got %b expected 0", hid_valid); else passed++;
        total++; if (hid !== 8'h00) $display("FAIL reset_hid: got %h expected 00", hid); else passed++;
        total++; if ({op_a, op_b, op_c, op_d, op_e, op_f} !== 18'h0) $display("FAIL reset_ops: got %h expected 0", {op_a, op_b, op_c, op_d, op_e, op_f}); else passed++;
        total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); else passed++;
    endtask

    task automatic test_default_table;
        logic [17:0] acc;
        run_sample('1, 1'b0, '0, '0);
        acc = '0;
        for (int k = 0; k < LAT; k++) acc |= op_log[k];
        total++; if (lat !== LAT) $display("FAIL default_latency: got %0d expected %0d", lat, LAT); else passed++;
        total++; if (hid !== 8'h00) $display("FAIL default_hid: got %h expected 00", hid); else passed++;
        total++; if (acc !== 18'h0) $display("FAIL default_ops: got %h expected 0", acc); else passed++;
        finish_run();
    endtask

    task automatic test_basic;
        cfg_write(6'd0, 4'd0);
        cfg_write(6'd1, 4'd1);
        run_sample(mk(3'd3, 3'd2), 1'b0, '0, '0);
        total++; if (lat !== LAT) $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); else passed++;
        total++; if (hid !== 8'h01) $display("FAIL basic_hid: got %h expected 01", hid); else passed++;
        total++; if (op_log[LAG][17:15] !== 3'd3) $display("FAIL basic_op_a: got %0d expected 3", op_log[LAG][17:15]); else passed++;
        total++; if (op_log[LAG][14:12] !== 3'd2) $display("FAIL basic_op_b: got %0d expected 2", op_log[LAG][14:12]); else passed++;
        total++; if (op_log[LAG][11:0] !== 12'h0) $display("FAIL basic_op_cf: got %h expected 000", op_log[LAG][11:0]); else passed++;
        total++; if (op_log[LAG+1] !== 18'h0) $display("FAIL basic_n1_ops: got %h expected 0", op_log[LAG+1]); else passed++;
        finish_run();
    endtask

    task automatic test_cfg_with_accept;
        run_sample(mk(3'd3, 3'd2), 1'b1, 6'd6, 4'd0);
        total++; if (hid !== 8'h03) $display("FAIL cfgacc_hid: got %h expected 03", hid); else passed++;
        total++; if (op_log[LAG+1][17:15] !== 3'd3) $display("FAIL cfgacc_n1_op_a: got %0d expected 3", op_log[LAG+1][17:15]); else passed++;
        finish_run();
    endtask

    task automatic test_cfg_errors;
        cfg_we = 1'b1; cfg_addr = 6'd48; cfg_data = 4'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b1) $display("FAIL err_addr48_pulse: got %b expected 1", cfg_err); else passed++;
        @(posedge clk); #1;
        total++; if (cfg_err !== 1'b0) $display("FAIL err_pulse_end: got %b expected 0", cfg_err); else passed++;
        in_feat = mk(3'd1, 3'd0); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b1; cfg_addr = 6'd12; cfg_data = 4'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b1) $display("FAIL err_run_pulse: got %b expected 1", cfg_err); else passed++;
        wait_valid();
        total++; if (hid !== 8'h03) $display("FAIL err_run_hid: got %h expected 03", hid); else passed++;
        finish_run();
        run_sample(mk(3'd3, 3'd2), 1'b0, '0, '0);
        total++; if (hid !== 8'h03) $display("FAIL err_table_unchanged: got %h expected 03", hid); else passed++;
        total++; if (op_log[LAG+2] !== 18'h0) $display("FAIL err_n2_ops: got %h expected 0", op_log[LAG+2]); else passed++;
        finish_run();
    endtask

    task automatic test_backpressure;
        hid_ready = 1'b0;
        run_sample(mk(3'd3, 3'd2), 1'b0, '0, '0);
        in_feat = mk(3'd0, 3'd0); in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready); else passed++;
            total++; if (hid_valid !== 1'b1) $display("FAIL bp_hid_valid c%0d: got %b expected 1", c, hid_valid); else passed++;
            total++; if (hid !== 8'h03) $display("FAIL bp_hid c%0d: got %h expected 03", c, hid); else passed++;
        end
        hid_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_idle_ready: got %b expected 1", in_ready); else passed++;
        total++; if (hid_valid !== 1'b0) $display("FAIL bp_idle_valid: got %b expected 0", hid_valid); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_accepted: got %b expected 0", in_ready); else passed++;
        total++; if (hid !== 8'h00) $display("FAIL bp_hid_cleared: got %h expected 00", hid); else passed++;
        wait_valid();
        total++; if (hid !== 8'h00) $display("FAIL bp_second_hid: got %h expected 00", hid); else passed++;
        finish_run();
    endtask

    task automatic test_back_to_back;
        int acc_c [2];
        int na;
        na = 0;
        acc_c[0] = 0; acc_c[1] = 0;
        in_feat = mk(3'd3, 3'd2); in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_valid && in_ready) begin
                acc_c[na] = c;
                na++;
                if (na == 2) break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (na !== 2) $display("FAIL b2b_accepts: got %0d expected 2", na); else passed++;
        total++; if (acc_c[1] - acc_c[0] !== N_NEUR + 2 + LAG) $display("FAIL b2b_period: got %0d expected %0d", acc_c[1] - acc_c[0], N_NEUR + 2 + LAG); else passed++;
        wait_valid();
        total++; if (hid !== 8'h03) $display("FAIL b2b_hid: got %h expected 03", hid); else passed++;
        finish_run();
    endtask

    task automatic test_reset_midrun;
        in_feat = mk(3'd3, 3'd2); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b expected 1", in_ready); else passed++;
        total++; if (hid_valid !== 1'b0) $display("FAIL mid_hid_valid: got %b expected 0", hid_valid); else passed++;
        total++; if (hid !== 8'h00) $display("FAIL mid_hid: got %h expected 00", hid); else passed++;
        total++; if ({op_a, op_b, op_c, op_d, op_e, op_f} !== 18'h0) $display("FAIL mid_ops: got %h expected 0", {op_a, op_b, op_c, op_d, op_e, op_f}); else passed++;
        run_sample(mk(3'd3, 3'd2), 1'b0, '0, '0);
        total++; if (lat !== LAT) $display("FAIL mid_rerun_latency: got %0d expected %0d", lat, LAT); else passed++;
        total++; if (hid !== 8'h00) $display("FAIL mid_table_cleared: got %h expected 00", hid); else passed++;
        total++; if (op_log[LAG] !== 18'h0) $display("FAIL mid_n0_ops: got %h expected 0", op_log[LAG]); else passed++;
        finish_run();
    endtask

    initial begin
        test_reset();
        test_default_table();
        test_basic();
        test_cfg_with_accept();
        test_cfg_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule
